// File: rtl/store_narrow_unit_pkg.sv
// Shared types for the 32-to-16 bit store narrowing unit: access sizes,
// FSM states and the registered request bundle.
package store_narrow_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        size_e       size;
    } req_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering for the 16-bit write port, plus the alignment
// check applied to an incoming request before it is accepted.
module store_lane_align
    import store_narrow_unit_pkg::*;
(
    input  logic [31:0] chk_addr_i,
    input  size_e       chk_size_i,
    output logic        misalign_o,
    input  req_t        req_i,
    input  state_e      state_i,
    output logic [31:0] beat_addr_o,
    output logic [15:0] beat_data_o,
    output logic [1:0]  beat_be_o
);

    logic [31:0] hi_addr;

    always_comb begin
        unique case (chk_size_i)
            SZ_BYTE: misalign_o = 1'b0;
            SZ_HALF: misalign_o = chk_addr_i[0];
            SZ_WORD: misalign_o = (chk_addr_i[1:0] != 2'b00);
            default: misalign_o = 1'b1;
        endcase
    end

    // Upper half of a word store; wraps naturally at the top of the address space.
    assign hi_addr = req_i.addr + 32'd2;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        beat_addr_o = '0;
        beat_data_o = '0;
        beat_be_o   = 2'b00;
        unique case (state_i)
            LO: begin
                beat_addr_o = req_i.addr & 32'hFFFF_FFFE;
                if (req_i.size == SZ_BYTE) begin
                    if (req_i.addr[0]) begin
                        beat_data_o = {req_i.data[7:0], 8'h00};
                        beat_be_o   = 2'b10;
                    end else begin
                        beat_data_o = {8'h00, req_i.data[7:0]};
                        beat_be_o   = 2'b01;
                    end
                end else begin
                    beat_data_o = req_i.data[15:0];
                    beat_be_o   = 2'b11;
                end
            end
            HI: begin
                beat_addr_o = hi_addr & 32'hFFFF_FFFE;
                beat_data_o = req_i.data[31:16];
                beat_be_o   = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Splits byte/halfword/word CPU stores into one or two beats on a 16-bit
// memory write port with valid/ack handshake; rejects misaligned requests.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic [1:0]  req_size_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [15:0] mem_data_o,
    output logic [1:0]  mem_be_o,
    input  logic        mem_ack_i,
    output logic        done_o,
    output logic        misalign_o
);

    state_e state_q, state_d;
    req_t   req_q, req_d;
    logic   done_q, done_d;
    logic   misalign_q, misalign_d;
    logic   req_misalign;
    logic   accept;

    store_lane_align u_lane_align (
        .chk_addr_i  (req_addr_i),
        .chk_size_i  (size_e'(req_size_i)),
        .misalign_o  (req_misalign),
        .req_i       (req_q),
        .state_i     (state_q),
        .beat_addr_o (mem_addr_o),
        .beat_data_o (mem_data_o),
        .beat_be_o   (mem_be_o)
    );

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_ready_o && req_valid_i;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d = '{addr: req_addr_i, data: req_data_i, size: size_e'(req_size_i)};
                    if (req_misalign) misalign_d = 1'b1;
                    else              state_d    = LO;
                end
            end
            LO: begin
                if (mem_ack_i) begin
                    if (req_q.size == SZ_WORD) begin
                        state_d = HI;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            HI: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    // Write-valid decodes straight from the state so an async reset drops it at once.
    assign mem_we_o   = (state_q != IDLE);
    assign done_o     = done_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: a reference model queues expected
// beats/completions per request and a negedge monitor pops and compares them.
module tb_store_narrow_unit;

    localparam int K_NONE = 0;
    localparam int K_BEAT = 1;
    localparam int K_DONE = 2;
    localparam int K_MIS  = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic [1:0]  mem_be_o;
    logic        mem_ack_i = 1'b1;
    logic        done_o;
    logic        misalign_o;

    int  checks = 0;
    int  failures = 0;
    ev_t sb[$];

    store_narrow_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_size_i  (req_size_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .done_o      (done_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ev_t mk(input int kind, input logic [31:0] a, input logic [15:0] d,
                               input logic [1:0] be);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.be = be;
        return e;
    endfunction

    // Reference model: expected beat sequence for one request.
    task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic bad;
        logic [31:0] al;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        al  = {a[31:1], 1'b0};
        if (bad) begin
            sb.push_back(mk(K_MIS, 0, 0, 0));
        end else begin
            case (sz)
                2'b00: if (a[0]) sb.push_back(mk(K_BEAT, al, {d[7:0], 8'h00}, 2'b10));
                       else      sb.push_back(mk(K_BEAT, al, {8'h00, d[7:0]}, 2'b01));
                2'b01: sb.push_back(mk(K_BEAT, al, d[15:0], 2'b11));
                default: begin
                    sb.push_back(mk(K_BEAT, a, d[15:0], 2'b11));
                    sb.push_back(mk(K_BEAT, a + 32'd2, d[31:16], 2'b11));
                end
            endcase
            sb.push_back(mk(K_DONE, 0, 0, 0));
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [15:0] d,
                           input logic [1:0] be);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event_kind", kind, K_NONE);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == K_BEAT && e.kind == K_BEAT) begin
                check("beat_addr", a, e.addr);
                check("beat_data", {16'h0, d}, {16'h0, e.data});
                check("beat_be", {30'h0, be}, {30'h0, e.be});
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (mem_we_o && mem_ack_i) observe(K_BEAT, mem_addr_o, mem_data_o, mem_be_o);
            if (done_o)                observe(K_DONE, 0, 0, 0);
            if (misalign_o)            observe(K_MIS, 0, 0, 0);
        end
    end

    // Called one time unit after a rising edge with the block in IDLE.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic push);
        if (push) model_push(a, d, sz);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        req_size_i  = sz;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("drain_remaining", sb.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"}, {31'h0, mem_we_o}, 0);
        check({tag, "_addr"}, mem_addr_o, 0);
        check({tag, "_data"}, {16'h0, mem_data_o}, 0);
        check({tag, "_be"}, {30'h0, mem_be_o}, 0);
        check({tag, "_ready"}, {31'h0, req_ready_o}, 1);
    endtask

    initial begin
        #2;
        check_idle("reset");
        check("reset_done", {31'h0, done_o}, 0);
        check("reset_mis", {31'h0, misalign_o}, 0);

        // Release between edges; the very next rising edge accepts.
        #10 rst_i = 1'b1;
        send(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b1);
        check("first_accept_we", {31'h0, mem_we_o}, 1);
        check("first_accept_ready", {31'h0, req_ready_o}, 0);
        drain();
        check_idle("after_word");

        send(32'h0000_0203, 32'h0000_00A5, 2'b00, 1'b1);
        drain();
        send(32'h0000_0200, 32'h1234_5677, 2'b00, 1'b1);
        drain();
        send(32'h0000_0402, 32'hFFFF_1234, 2'b01, 1'b1);
        drain();

        send(32'h0000_0011, 32'h0000_5555, 2'b01, 1'b1);
        check("mis_half_ready", {31'h0, req_ready_o}, 1);
        check("mis_half_we", {31'h0, mem_we_o}, 0);
        drain();
        send(32'h0000_0020, 32'h0000_5555, 2'b11, 1'b1);
        check("mis_sz11_ready", {31'h0, req_ready_o}, 1);
        check("mis_sz11_we", {31'h0, mem_we_o}, 0);
        drain();

        // Backpressure with request inputs toggling mid-store.
        mem_ack_i = 1'b0;
        send(32'h0000_0300, 32'hCAFE_F00D, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_data_i  = 32'h1111_1111 ^ i;
            req_size_i  = 2'b00;
            check("stall_we", {31'h0, mem_we_o}, 1);
            check("stall_addr", mem_addr_o, 32'h0000_0300);
            check("stall_data", {16'h0, mem_data_o}, 32'h0000_F00D);
            check("stall_be", {30'h0, mem_be_o}, 3);
            check("stall_ready", {31'h0, req_ready_o}, 0);
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        mem_ack_i   = 1'b1;
        drain();
        check_idle("after_stall");

        // Reset while the HI beat is pending: only the LO beat is expected.
        mem_ack_i = 1'b0;
        sb.push_back(mk(K_BEAT, 32'h0000_0500, 16'h3344, 2'b11));
        send(32'h0000_0500, 32'h1122_3344, 2'b10, 1'b0);
        mem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("hi_addr", mem_addr_o, 32'h0000_0502);
        check("hi_data", {16'h0, mem_data_o}, 32'h0000_1122);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_we", {31'h0, mem_we_o}, 0);
        check("async_rst_ready", {31'h0, req_ready_o}, 1);
        check("async_rst_done", {31'h0, done_o}, 0);
        @(posedge clk_i); #1;
        check("rst_no_done", {31'h0, done_o}, 0);
        check_idle("in_reset");
        rst_i     = 1'b1;
        mem_ack_i = 1'b1;
        send(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b1);
        drain();

        send(32'hFFFF_FFFC, 32'h8765_4321, 2'b10, 1'b1);
        drain();
        send(32'hFFFF_FFFE, 32'h8765_4321, 2'b10, 1'b1);
        drain();

        repeat (3) @(posedge clk_i);
        #1;
        check("final_sb_empty", sb.size(), 0);
        check_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_narrow_unit.md
STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

Interface
REQ-001 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port req_valid_i, input, 1 bit: the CPU presents a store request.
REQ-004 The block SHALL have the port req_ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-005 The block SHALL have the port req_addr_i, input, 32 bits: store byte address.
REQ-006 The block SHALL have the port req_data_i, input, 32 bits: store data, right-justified.
REQ-007 The block SHALL have the port req_size_i, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 The block SHALL have the port mem_we_o, output, 1 bit: write beat valid on the 16-bit memory port.
REQ-009 The block SHALL have the port mem_addr_o, output, 32 bits: halfword-aligned beat address, with bit0 always 0.
REQ-010 The block SHALL have the port mem_data_o, output, 16 bits: beat data.
REQ-011 The block SHALL have the port mem_be_o, output, 2 bits: byte enables, where bit0 is lane [7:0] and bit1 is lane [15:8].
REQ-012 The block SHALL have the port mem_ack_i, input, 1 bit: memory accepts the current beat.
REQ-013 The block SHALL have the port done_o, output, 1 bit: one-cycle pulse when a store completes.
REQ-014 The block SHALL have the port misalign_o, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-015 The block SHALL implement a state machine with the states IDLE, LO and HI.
REQ-016 req_ready_o SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid_i=1 and req_ready_o=1.
REQ-017 On accept, addr, data and size SHALL be registered; the req_* inputs SHALL be ignored until the block returns to IDLE.
REQ-018 A request SHALL be misaligned when the size is halfword with addr[0]=1, word with addr[1:0]!=00, or size is 11.
REQ-019 A misaligned accept SHALL pulse misalign_o for the next cycle, issue no beat, and leave the state in IDLE.
REQ-020 A legal accept SHALL move the state to LO; mem_we_o SHALL be 1 from the cycle after the accept (latency 1).
REQ-021 In LO, mem_addr_o SHALL be {addr[31:1],0}.
REQ-022 In LO for a byte store, when addr[0]=0 the block SHALL drive data={8'h00,d[7:0]} and be=01.
REQ-023 In LO for a byte store, when addr[0]=1 the block SHALL drive data={d[7:0],8'h00} and be=10.
REQ-024 In LO for a halfword or word store, the block SHALL drive data=d[15:0] and be=11.
REQ-025 In HI (word only), the block SHALL drive mem_addr_o=addr+2, data=d[31:16] and be=11.
REQ-026 The mem_* outputs SHALL hold stable while mem_we_o=1 and mem_ack_i=0; there SHALL be no timeout.
REQ-027 An ack in LO for a word store SHALL move the state to HI; an ack in LO for a byte or halfword store SHALL return the state to IDLE and pulse done_o.
REQ-028 An ack in HI SHALL return the state to IDLE and pulse done_o.
REQ-029 In IDLE, mem_we_o SHALL be 0, mem_be_o SHALL be 00, and mem_data_o and mem_addr_o SHALL be 0.
REQ-030 mem_ack_i arriving while mem_we_o=0 SHALL be ignored.
REQ-031 A new request MAY be accepted in the cycle after done_o; the block SHALL provide no same-cycle accept on completion.
REQ-032 The addr+2 computation SHALL wrap modulo 2^32 with no error.

Reset
REQ-033 On rst_i=0, the state SHALL go immediately (asynchronously) to IDLE, all outputs SHALL be 0 except req_ready_o=1, and the registered request SHALL be cleared.
REQ-034 A reset asserted mid-store SHALL abort the store; mem_we_o SHALL drop without waiting for the clock, and no done_o SHALL be produced.
REQ-035 The first accept SHALL be possible on the first rising edge after rst_i deasserts.

Structure
REQ-036 A shared package SHALL hold the size encodings (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10) and the state enum.
REQ-037 Lane steering and misalignment detection SHALL reside in one combinational sub-module, store_lane_align.
REQ-038 The state register and request registers SHALL reside in store_narrow_unit.

Verification
REQ-039 Word store: addr=0x100, d=0xDEADBEEF, ack held high -> beat (0x100, 0xBEEF, be=11), then beat (0x102, 0xDEAD, be=11); done_o pulses after the second beat.
REQ-040 Byte store: addr=0x203, d=0x000000A5 -> single beat (0x202, 0xA500, be=10), followed by done_o.
REQ-041 Misaligned store: halfword at addr=0x11, and separately size=11 -> misalign_o pulses once each, mem_we_o stays 0, and req_ready_o=1 in the next cycle.
REQ-042 Backpressure: word store with ack withheld 3 cycles in LO -> mem_* outputs stable through the stall; HI beat follows the ack; req_valid_i and req_data_i changed mid-store are ignored.
REQ-043 Reset mid-operation: rst_i=0 in HI -> mem_we_o=0 immediately with no done_o; the next word store after release behaves as in REQ-039.
REQ-044 Wrap-around: word store at addr=0xFFFFFFFC -> beat addresses 0xFFFFFFFC then 0xFFFFFFFE; word store at 0xFFFFFFFE -> misalign_o.
